// File: rtl/axi4_bound_err_responder.sv
// Terminating AXI4 slave for boundary-rejected bursts: it drains write data and
// returns SLVERR on B, and it returns len+1 zero-data SLVERR beats on R.
module axi4_bound_err_responder #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [1:0]  ERR_RESP   = 2'b10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // write address / data / response
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic [7:0]            aw_len_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  // read address / data
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [7:0]            ar_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  // status
  output logic                  wlast_mismatch_o,
  output logic                  busy_o
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [1:0]          w_state;
  logic [ID_WIDTH-1:0] w_id;
  logic [7:0]          w_len;
  logic [7:0]          w_cnt;
  logic                w_mismatch;

  logic [0:0]          r_state;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;

  logic                w_at_len;
  logic                r_at_len;

  assign w_at_len = (w_cnt == w_len);
  assign r_at_len = (r_cnt == r_len);

  // Write engine: data phase ends on WLAST or on the AWLEN-th beat, whichever
  // comes first; disagreement between the two is flagged one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state    <= W_IDLE;
      w_id       <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_mismatch <= 1'b0;
    end else begin
      w_mismatch <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (aw_valid_i) begin
            w_id    <= aw_id_i;
            w_len   <= aw_len_i;
            w_cnt   <= '0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_last_i || w_at_len) begin
              w_state    <= W_RESP;
              w_mismatch <= w_last_i ^ w_at_len;
            end
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read engine: counter stops at len, so len=255 never wraps before RLAST.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_valid_i) begin
            r_id    <= ar_id_i;
            r_len   <= ar_len_i;
            r_cnt   <= '0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (r_at_len) begin
              r_state <= R_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign aw_ready_o       = (w_state == W_IDLE);
  assign w_ready_o        = (w_state == W_DATA);
  assign b_valid_o        = (w_state == W_RESP);
  assign b_id_o           = w_id;
  assign b_resp_o         = ERR_RESP;
  assign wlast_mismatch_o = w_mismatch;

  assign ar_ready_o = (r_state == R_IDLE);
  assign r_valid_o  = (r_state == R_DATA);
  assign r_id_o     = r_id;
  assign r_data_o   = '0;
  assign r_resp_o   = ERR_RESP;
  assign r_last_o   = (r_state == R_DATA) && r_at_len;

  assign busy_o = (w_state != W_IDLE) || (r_state != R_IDLE);

endmodule

// File: tb/tb_axi4_bound_err_responder.sv
// Directed bench for axi4_bound_err_responder with R/B scoreboard queues.
module tb_axi4_bound_err_responder;

  localparam int unsigned IDW = 4;
  localparam int unsigned DW  = 64;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           aw_valid_i, aw_ready_o;
  logic [IDW-1:0] aw_id_i;
  logic [7:0]     aw_len_i;
  logic           w_valid_i, w_ready_o, w_last_i;
  logic           b_valid_o, b_ready_i;
  logic [IDW-1:0] b_id_o;
  logic [1:0]     b_resp_o;
  logic           ar_valid_i, ar_ready_o;
  logic [IDW-1:0] ar_id_i;
  logic [7:0]     ar_len_i;
  logic           r_valid_o, r_ready_i;
  logic [IDW-1:0] r_id_o;
  logic [DW-1:0]  r_data_o;
  logic [1:0]     r_resp_o;
  logic           r_last_o;
  logic           wlast_mismatch_o, busy_o;

  always #5 clk_i = ~clk_i;

  axi4_bound_err_responder #(
    .ID_WIDTH  (IDW),
    .DATA_WIDTH(DW),
    .ERR_RESP  (2'b10)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .aw_valid_i      (aw_valid_i),
    .aw_ready_o      (aw_ready_o),
    .aw_id_i         (aw_id_i),
    .aw_len_i        (aw_len_i),
    .w_valid_i       (w_valid_i),
    .w_ready_o       (w_ready_o),
    .w_last_i        (w_last_i),
    .b_valid_o       (b_valid_o),
    .b_ready_i       (b_ready_i),
    .b_id_o          (b_id_o),
    .b_resp_o        (b_resp_o),
    .ar_valid_i      (ar_valid_i),
    .ar_ready_o      (ar_ready_o),
    .ar_id_i         (ar_id_i),
    .ar_len_i        (ar_len_i),
    .r_valid_o       (r_valid_o),
    .r_ready_i       (r_ready_i),
    .r_id_o          (r_id_o),
    .r_data_o        (r_data_o),
    .r_resp_o        (r_resp_o),
    .r_last_o        (r_last_o),
    .wlast_mismatch_o(wlast_mismatch_o),
    .busy_o          (busy_o)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           last;
  } rexp_t;

  rexp_t          rq[$];
  logic [IDW-1:0] bq[$];

  int vectors     = 0;
  int miscompares = 0;
  int mm_cnt      = 0;

  logic           p_rstall = 1'b0, p_bstall = 1'b0;
  logic [IDW-1:0] p_rid, p_bid;
  logic           p_rlast;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge: a valid&ready seen here completes on the next rising edge.
  task automatic monitor();
    rexp_t e;
    if (rst_ni) begin
      if (p_rstall) begin
        chk("r_hold_valid", 64'(r_valid_o), 64'(1));
        chk("r_hold_id", 64'(r_id_o), 64'(p_rid));
        chk("r_hold_last", 64'(r_last_o), 64'(p_rlast));
      end
      if (p_bstall) begin
        chk("b_hold_valid", 64'(b_valid_o), 64'(1));
        chk("b_hold_id", 64'(b_id_o), 64'(p_bid));
      end
      if (r_valid_o) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 64'(r_valid_o), 64'(0));
        end else begin
          e = rq[0];
          chk("r_id", 64'(r_id_o), 64'(e.id));
          chk("r_last", 64'(r_last_o), 64'(e.last));
          chk("r_data", r_data_o, 64'(0));
          chk("r_resp", 64'(r_resp_o), 64'(2'b10));
          if (r_ready_i) void'(rq.pop_front());
        end
      end
      if (b_valid_o) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 64'(b_valid_o), 64'(0));
        end else begin
          chk("b_id", 64'(b_id_o), 64'(bq[0]));
          chk("b_resp", 64'(b_resp_o), 64'(2'b10));
          if (b_ready_i) void'(bq.pop_front());
        end
      end
      if (wlast_mismatch_o) mm_cnt++;
    end
    p_rstall = rst_ni && r_valid_o && !r_ready_i;
    p_bstall = rst_ni && b_valid_o && !b_ready_i;
    p_rid    = r_id_o;
    p_rlast  = r_last_o;
    p_bid    = b_id_o;
  endtask

  task automatic cyc();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_aw(input logic [IDW-1:0] id, input logic [7:0] len);
    int m = 0;
    aw_valid_i = 1'b1;
    aw_id_i    = id;
    aw_len_i   = len;
    bq.push_back(id);
    while (!aw_ready_o && m < 50) begin
      cyc();
      m++;
    end
    chk("aw_ready_wait", 64'(aw_ready_o), 64'(1));
    cyc();
    aw_valid_i = 1'b0;
    chk("w_ready_lat", 64'(w_ready_o), 64'(1));
  endtask

  task automatic do_w(input logic last);
    int m = 0;
    w_valid_i = 1'b1;
    w_last_i  = last;
    while (!w_ready_o && m < 50) begin
      cyc();
      m++;
    end
    chk("w_ready_wait", 64'(w_ready_o), 64'(1));
    cyc();
    w_valid_i = 1'b0;
    w_last_i  = 1'b0;
  endtask

  task automatic drain_b();
    int n = 0;
    b_ready_i = 1'b1;
    while (bq.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    b_ready_i = 1'b0;
    chk("b_drain", 64'(bq.size()), 64'(0));
  endtask

  initial begin
    int n, m0, wn;
    logic wh;
    rst_ni     = 1'b0;
    aw_valid_i = 1'b0; aw_id_i = '0; aw_len_i = '0;
    w_valid_i  = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b0;
    ar_valid_i = 1'b0; ar_id_i = '0; ar_len_i = '0; r_ready_i = 1'b0;
    repeat (3) cyc();
    chk("rst_aw_ready", 64'(aw_ready_o), 64'(1));
    chk("rst_ar_ready", 64'(ar_ready_o), 64'(1));
    chk("rst_w_ready", 64'(w_ready_o), 64'(0));
    chk("rst_b_valid", 64'(b_valid_o), 64'(0));
    chk("rst_r_valid", 64'(r_valid_o), 64'(0));
    chk("rst_r_last", 64'(r_last_o), 64'(0));
    chk("rst_mismatch", 64'(wlast_mismatch_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    rst_ni = 1'b1;
    cyc();

    // read burst id=5 len=3, r_ready toggling
    ar_valid_i = 1'b1; ar_id_i = 4'd5; ar_len_i = 8'd3;
    for (int i = 0; i < 4; i++) rq.push_back('{id: 4'd5, last: (i == 3)});
    chk("ar_ready_idle", 64'(ar_ready_o), 64'(1));
    cyc();
    ar_valid_i = 1'b0;
    chk("r_valid_lat", 64'(r_valid_o), 64'(1));
    chk("ar_ready_busy", 64'(ar_ready_o), 64'(0));
    n = 0;
    while (rq.size() != 0 && n < 40) begin
      r_ready_i = (n % 2 == 0);
      cyc();
      n++;
    end
    r_ready_i = 1'b0;
    chk("rd_drain", 64'(rq.size()), 64'(0));
    chk("rd_cycles", 64'(n), 64'(7));
    chk("ar_ready_after", 64'(ar_ready_o), 64'(1));
    chk("r_valid_after", 64'(r_valid_o), 64'(0));

    // single-beat write
    m0 = mm_cnt;
    do_aw(4'd2, 8'd0);
    do_w(1'b1);
    chk("b_valid_lat", 64'(b_valid_o), 64'(1));
    chk("w_ready_drop", 64'(w_ready_o), 64'(0));
    drain_b();
    chk("aw_ready_after_b", 64'(aw_ready_o), 64'(1));
    chk("mm_none_single", 64'(mm_cnt), 64'(m0));

    // early WLAST on beat 3 of 8
    m0 = mm_cnt;
    do_aw(4'd6, 8'd7);
    do_w(1'b0); do_w(1'b0); do_w(1'b1);
    chk("w_ready_early", 64'(w_ready_o), 64'(0));
    chk("b_valid_early", 64'(b_valid_o), 64'(1));
    drain_b();
    chk("mm_early", 64'(mm_cnt), 64'(m0 + 1));

    // missing WLAST, len=1
    do_aw(4'd7, 8'd1);
    do_w(1'b0); do_w(1'b0);
    chk("w_ready_nolast", 64'(w_ready_o), 64'(0));
    chk("b_valid_nolast", 64'(b_valid_o), 64'(1));
    drain_b();
    chk("mm_nolast", 64'(mm_cnt), 64'(m0 + 2));

    // B back-pressure for 5 cycles
    do_aw(4'd9, 8'd0);
    do_w(1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_b_valid", 64'(b_valid_o), 64'(1));
      chk("bp_b_id", 64'(b_id_o), 64'(9));
      chk("bp_aw_ready", 64'(aw_ready_o), 64'(0));
      cyc();
    end
    chk("bp_queued", 64'(bq.size()), 64'(1));
    b_ready_i = 1'b1;
    cyc();
    b_ready_i = 1'b0;
    chk("bp_done", 64'(bq.size()), 64'(0));
    chk("bp_aw_ready_after", 64'(aw_ready_o), 64'(1));
    chk("bp_b_valid_after", 64'(b_valid_o), 64'(0));

    // concurrent AW len=1 and AR len=255
    m0 = mm_cnt;
    aw_valid_i = 1'b1; aw_id_i = 4'd1; aw_len_i = 8'd1;
    ar_valid_i = 1'b1; ar_id_i = 4'd3; ar_len_i = 8'd255;
    bq.push_back(4'd1);
    for (int i = 0; i < 256; i++) rq.push_back('{id: 4'd3, last: (i == 255)});
    chk("cc_aw_ready", 64'(aw_ready_o), 64'(1));
    chk("cc_ar_ready", 64'(ar_ready_o), 64'(1));
    cyc();
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    chk("cc_w_ready", 64'(w_ready_o), 64'(1));
    chk("cc_r_valid", 64'(r_valid_o), 64'(1));
    r_ready_i = 1'b1; b_ready_i = 1'b1; w_valid_i = 1'b1; w_last_i = 1'b0;
    wn = 0; n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 400) begin
      wh = w_valid_i && w_ready_o;
      chk("cc_busy", 64'(busy_o), 64'(1));
      cyc();
      n++;
      if (wh) begin
        wn++;
        w_last_i = (wn == 1);
        if (wn == 2) begin
          w_valid_i = 1'b0;
          w_last_i  = 1'b0;
        end
      end
    end
    r_ready_i = 1'b0; b_ready_i = 1'b0;
    chk("cc_r_drain", 64'(rq.size()), 64'(0));
    chk("cc_b_drain", 64'(bq.size()), 64'(0));
    chk("cc_cycles", 64'(n), 64'(256));
    chk("cc_w_beats", 64'(wn), 64'(2));
    chk("cc_busy_end", 64'(busy_o), 64'(0));
    chk("cc_mm_none", 64'(mm_cnt), 64'(m0));

    // reset during R beat 2 of 8 with W_DATA active
    aw_valid_i = 1'b1; aw_id_i = 4'd4; aw_len_i = 8'd3;
    ar_valid_i = 1'b1; ar_id_i = 4'd10; ar_len_i = 8'd7;
    bq.push_back(4'd4);
    for (int i = 0; i < 8; i++) rq.push_back('{id: 4'd10, last: (i == 7)});
    cyc();
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    r_ready_i = 1'b1;
    cyc();
    chk("mr_r_valid_pre", 64'(r_valid_o), 64'(1));
    chk("mr_w_ready_pre", 64'(w_ready_o), 64'(1));
    chk("mr_beats_left", 64'(rq.size()), 64'(7));
    rst_ni = 1'b0;
    rq.delete();
    bq.delete();
    #1;
    chk("mr_r_valid", 64'(r_valid_o), 64'(0));
    chk("mr_w_ready", 64'(w_ready_o), 64'(0));
    chk("mr_b_valid", 64'(b_valid_o), 64'(0));
    chk("mr_aw_ready", 64'(aw_ready_o), 64'(1));
    chk("mr_ar_ready", 64'(ar_ready_o), 64'(1));
    chk("mr_busy", 64'(busy_o), 64'(0));
    chk("mr_r_last", 64'(r_last_o), 64'(0));
    cyc();
    cyc();
    rst_ni = 1'b1;
    b_ready_i = 1'b1; w_valid_i = 1'b1; w_last_i = 1'b1;
    repeat (10) cyc();
    chk("post_r_valid", 64'(r_valid_o), 64'(0));
    chk("post_b_valid", 64'(b_valid_o), 64'(0));
    chk("post_w_ready", 64'(w_ready_o), 64'(0));
    chk("post_busy", 64'(busy_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
